// File: rtl/register_manager_pkg.sv
// register_manager_pkg: shared CPU parameters, register index and issue types, bypass hit helper
package register_manager_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  typedef logic [4:0] reg_idx_t;
  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     rd_v;
  } issue_t;
  // A write-back in flight on a nonzero index satisfies a reader of that index this cycle.
  function automatic logic src_hit(input logic v, input reg_idx_t wb_idx, input reg_idx_t src);
    return v & (wb_idx == src) & (src != '0);
  endfunction
endpackage

// File: rtl/register_manager_regfile.sv
// register_manager_regfile: 2-read/1-write integer register file, x0 hardwired to zero
//  clk, rst       clock, asynchronous active-high clear
//  i_we/i_wa/i_wd write enable, index, data (writes to x0 dropped)
//  i_ra1/i_ra2    combinational read indices
//  o_rd1/o_rd2    read data
module register_manager_regfile
  import register_manager_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);
  logic [XLEN-1:0] r_regs [NREGS];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != '0) begin
      r_regs[i_wa] <= i_wd;
    end
  end
  assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
endmodule

// File: rtl/register_manager.sv
// register_manager: register file + scoreboard; hazard-checked issue with write-back bypass into a 1-entry operand buffer
//  wb_result/wb_rd/wb_result_v   retiring write-back, consumed every cycle
//  id_valid/id_rs1/id_rs2/id_rd/id_rd_v, id_ready   decode issue handshake
//  flush                         clears scoreboard and operand buffer
//  op1/op2/op_rd/op_rd_v/op_v, op_ready   operand buffer to execute
module register_manager
  import register_manager_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] wb_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_result_v,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_rd_v,
  output logic            id_ready,
  input  logic            flush,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [4:0]      op_rd,
  output logic            op_rd_v,
  output logic            op_v,
  input  logic            op_ready
);
  issue_t          w_iss;
  logic [XLEN-1:0] w_rd1, w_rd2, w_op1, w_op2;
  logic            w_hit1, w_hit2, w_hitrd, w_hazard, w_fire, w_pop;
  logic [NREGS-1:0] r_busy, w_busy_nxt;
  logic [XLEN-1:0] r_op1, r_op2;
  logic [4:0]      r_op_rd;
  logic            r_op_rd_v, r_op_v;

  assign w_iss = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, rd_v: id_rd_v};

  register_manager_regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (wb_result_v),
    .i_wa  (wb_rd),
    .i_wd  (wb_result),
    .i_ra1 (w_iss.rs1),
    .i_ra2 (w_iss.rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  assign w_hit1  = src_hit(wb_result_v, wb_rd, w_iss.rs1);
  assign w_hit2  = src_hit(wb_result_v, wb_rd, w_iss.rs2);
  assign w_hitrd = src_hit(wb_result_v, wb_rd, w_iss.rd);

  // All three indices are checked even if the instruction ignores a source; conservative but simple.
  assign w_hazard = (r_busy[w_iss.rs1] & ~w_hit1) |
                    (r_busy[w_iss.rs2] & ~w_hit2) |
                    (w_iss.rd_v & r_busy[w_iss.rd] & ~w_hitrd);
  assign id_ready = ~w_hazard & ~flush & (~r_op_v | op_ready);
  assign w_fire   = id_valid & id_ready;
  assign w_pop    = r_op_v & op_ready;

  assign w_op1 = (w_iss.rs1 == '0) ? '0 : w_hit1 ? wb_result : w_rd1;
  assign w_op2 = (w_iss.rs2 == '0) ? '0 : w_hit2 ? wb_result : w_rd2;

  // Issue set is applied after the write-back clear so a same-cycle set on the same rd wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_result_v) w_busy_nxt[wb_rd] = 1'b0;
    if (w_fire && w_iss.rd_v) w_busy_nxt[w_iss.rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    if (flush) w_busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_op_v    <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_op_rd   <= '0;
      r_op_rd_v <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_op_v <= 1'b0;
      end else if (w_fire) begin
        r_op_v    <= 1'b1;
        r_op1     <= w_op1;
        r_op2     <= w_op2;
        r_op_rd   <= w_iss.rd;
        r_op_rd_v <= w_iss.rd_v;
      end else if (w_pop) begin
        r_op_v <= 1'b0;
      end
    end
  end

  assign op1     = r_op1;
  assign op2     = r_op2;
  assign op_rd   = r_op_rd;
  assign op_rd_v = r_op_rd_v;
  assign op_v    = r_op_v;
endmodule

// File: tb/tb_register_manager.sv
// tb_register_manager: directed-vector self-checking bench for register_manager
module tb_register_manager;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_result = '0;
  logic [4:0]  wb_rd = '0;
  logic        wb_result_v = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rd_v = 1'b0;
  logic        id_ready;
  logic        flush = 1'b0;
  logic [31:0] op1, op2;
  logic [4:0]  op_rd;
  logic        op_rd_v, op_v;
  logic        op_ready = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  register_manager dut (
    .clk(clk), .rst(rst),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_result_v(wb_result_v),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_v(id_rd_v),
    .id_ready(id_ready), .flush(flush),
    .op1(op1), .op2(op2), .op_rd(op_rd), .op_rd_v(op_rd_v), .op_v(op_v), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] val);
    wb_result_v = v;
    wb_rd = rd;
    wb_result = val;
  endtask

  task automatic iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rdv);
    id_valid = v;
    id_rs1 = rs1;
    id_rs2 = rs2;
    id_rd = rd;
    id_rd_v = rdv;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_op_v", {31'd0, op_v}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op_rd_v", {31'd0, op_rd_v}, 32'd0);
    chk("rst_ready", {31'd0, id_ready}, 32'd1);
    // 1: write x5, then read it back through an issue
    wb(1, 5, 32'hDEAD_BEEF);
    step();
    wb(0, 0, 0);
    iss(1, 5, 0, 0, 0);
    #1 chk("t1_ready", {31'd0, id_ready}, 32'd1);
    chk("t1_op_v_before", {31'd0, op_v}, 32'd0);
    step();
    iss(0, 0, 0, 0, 0);
    chk("t1_op_v", {31'd0, op_v}, 32'd1);
    chk("t1_op1", op1, 32'hDEAD_BEEF);
    chk("t1_op2", op2, 32'd0);
    op_ready = 1'b1;
    step();
    chk("t1_pop", {31'd0, op_v}, 32'd0);
    // 2: RAW on x7 stalls until write-back, which bypasses in the same cycle
    iss(1, 0, 0, 7, 1);
    step();
    chk("t2_op_rd", {27'd0, op_rd}, 32'd7);
    iss(1, 7, 0, 0, 0);
    #1 chk("t2_stall0", {31'd0, id_ready}, 32'd0);
    step();
    chk("t2_stall1", {31'd0, id_ready}, 32'd0);
    chk("t2_popped", {31'd0, op_v}, 32'd0);
    wb(1, 7, 32'h0000_1234);
    #1 chk("t2_ready_bypass", {31'd0, id_ready}, 32'd1);
    step();
    wb(0, 0, 0);
    iss(0, 0, 0, 0, 0);
    chk("t2_op1_bypass", op1, 32'h0000_1234);
    chk("t2_op_v", {31'd0, op_v}, 32'd1);
    step();
    iss(0, 7, 0, 7, 1);
    #1 chk("t2_busy_clear", {31'd0, id_ready}, 32'd1);
    // 3: x0 writes ignored, x0 never busy
    wb(1, 0, 32'hFFFF_FFFF);
    iss(0, 0, 0, 0, 0);
    step();
    wb(0, 0, 0);
    iss(1, 0, 0, 0, 1);
    #1 chk("t3_ready", {31'd0, id_ready}, 32'd1);
    step();
    chk("t3_op1", op1, 32'd0);
    chk("t3_op_rd_v", {31'd0, op_rd_v}, 32'd1);
    chk("t3_no_busy0", {31'd0, id_ready}, 32'd1);
    step();
    iss(0, 0, 0, 0, 0);
    step();
    // 4: back-pressure holds buffer; pop and fire in one cycle reloads it
    op_ready = 1'b0;
    iss(1, 5, 7, 0, 0);
    step();
    chk("t4_op1", op1, 32'hDEAD_BEEF);
    chk("t4_op2", op2, 32'h0000_1234);
    iss(1, 7, 5, 0, 0);
    #1 chk("t4_bp_ready", {31'd0, id_ready}, 32'd0);
    step();
    chk("t4_hold_op1", op1, 32'hDEAD_BEEF);
    chk("t4_hold_op_v", {31'd0, op_v}, 32'd1);
    op_ready = 1'b1;
    #1 chk("t4_ready", {31'd0, id_ready}, 32'd1);
    step();
    iss(0, 0, 0, 0, 0);
    chk("t4_reload_op_v", {31'd0, op_v}, 32'd1);
    chk("t4_reload_op1", op1, 32'h0000_1234);
    chk("t4_reload_op2", op2, 32'hDEAD_BEEF);
    step();
    chk("t4_drain", {31'd0, op_v}, 32'd0);
    // 5: flush clears scoreboard and buffer
    op_ready = 1'b0;
    iss(1, 0, 0, 3, 1);
    step();
    iss(0, 3, 0, 0, 0);
    #1 chk("t5_busy3", {31'd0, id_ready}, 32'd0);
    flush = 1'b1;
    #1 chk("t5_flush_ready", {31'd0, id_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1 chk("t5_op_v", {31'd0, op_v}, 32'd0);
    chk("t5_ready", {31'd0, id_ready}, 32'd1);
    // 6: same-cycle clear and set on x4 -> set wins
    op_ready = 1'b1;
    wb(1, 4, 32'h0000_0044);
    iss(1, 0, 0, 4, 1);
    #1 chk("t6_ready", {31'd0, id_ready}, 32'd1);
    step();
    wb(0, 0, 0);
    iss(0, 4, 0, 0, 0);
    #1 chk("t6_stall", {31'd0, id_ready}, 32'd0);
    chk("t6_op_rd", {27'd0, op_rd}, 32'd4);
    // async reset mid-operation clears state without a clock edge
    #1 rst = 1'b1;
    #1 chk("ar_op_v", {31'd0, op_v}, 32'd0);
    chk("ar_ready", {31'd0, id_ready}, 32'd1);
    step();
    rst = 1'b0;
    op_ready = 1'b0;
    iss(1, 5, 7, 0, 0);
    step();
    iss(0, 0, 0, 0, 0);
    chk("ar_regs_op1", op1, 32'd0);
    chk("ar_regs_op2", op2, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
